mop_load_sched: RTL and testbench
=================================

# mop_load_sched

Arbitration and sequencing controller for the debug MOP instruction-load path. Up to NB_REQ requesters each deliver a fixed-length burst of 8-bit instruction values to one target peripheral. The block grants one requester at a time in round-robin order and checks the target against the register-lock vector. It then streams the burst onto the shared `instrut_value` / `load_ctrl` strobe pair that feeds the peripherals.

## Interface
- NB_REQ, 4, number of requesters (2..8)
- NB_TGT, 16, number of target peripherals (width of load_ctrl_o)
- BURST_LEN, 8, values per burst (1..15)
- TIMEOUT, 255, idle cycles tolerated mid-burst before abort (1..255)
- TW, $clog2(NB_TGT), target index width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- req_i  in  NB_REQ  per-requester load request (level, held until done/abort)
- tgt_i  in  NB_REQ*TW  per-requester target index, slice r = [r*TW +: TW]
- data_i  in  NB_REQ*8  per-requester instruction value, slice r = [r*8 +: 8]
- data_valid_i  in  NB_REQ  per-requester data valid
- lock_i  in  NB_TGT  1 = target locked, load forbidden
- data_ready_o  out  NB_REQ  ready, only the granted bit can be 1
- gnt_o  out  NB_REQ  one-hot grant (all-zero when idle)
- done_o  out  NB_REQ  1-cycle pulse, burst completed
- abort_o  out  NB_REQ  1-cycle pulse, burst rejected or aborted
- load_ctrl_o  out  NB_TGT  one-hot per-value load strobe
- instrut_value_o  out  8  value accompanying load_ctrl_o
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, DONE, ABORT.
- IDLE: if any req_i is set, pick the winner by round-robin, searching upward from rr_ptr with wrap. Register gnt_o, the winner index and the winner's tgt.
  - Target >= NB_TGT or lock_i[tgt]=1 (sampled that cycle): go to ABORT.
  - Otherwise go to LOAD with count=0 and timer=0.
- LOAD:
  - data_ready_o[winner]=1 combinationally; all other bits are 0.
  - Transfer when data_valid_i[winner] & ready: instrut_value_o<=data, load_ctrl_o<=onehot(tgt), count++, timer<=0.
  - Transfer with count==BURST_LEN-1: go to DONE.
  - Non-transfer cycle: load_ctrl_o<=0, timer++.
  - timer==TIMEOUT-1 without a transfer: go to ABORT.
  - req_i[winner] deasserted in LOAD: go to ABORT. This takes priority over a same-cycle transfer; that value is dropped and no strobe is issued.
  - lock_i[tgt] rising mid-burst: go to ABORT. Same priority.
- DONE: done_o[winner]=1, gnt_o<=0, load_ctrl_o<=0, rr_ptr<=winner+1 mod NB_REQ, then go to IDLE.
- ABORT: abort_o[winner]=1, then the same cleanup as DONE.
- instrut_value_o holds its last value between transfers. Only load_ctrl_o qualifies it.
- Requests from non-granted requesters are ignored until the block returns to IDLE. They are never lost while req_i stays high.
- count is 4 bits and timer is 8 bits; neither wraps within legal parameter ranges.

## Timing
- Reset (async, rst_ni=0): state=IDLE, rr_ptr=0, count=0, timer=0.
  - All outputs reset to 0: gnt_o, data_ready_o, done_o, abort_o, load_ctrl_o, instrut_value_o, busy_o.
- gnt_o and busy_o assert 1 cycle after req_i is seen in IDLE.
- load_ctrl_o/instrut_value_o appear 1 cycle after each valid&ready handshake and last exactly 1 cycle per value.
- Minimum burst occupancy is BURST_LEN+2 cycles (grant, BURST_LEN transfers, DONE).
- The IDLE following DONE/ABORT can grant on its first cycle. Back-to-back bursts have a 1-cycle IDLE gap.
- Reset asserted mid-burst: immediate return to reset values. No done/abort pulse is issued and no strobe follows.

## Structure
- Package mop_sched_pkg: state enum (IDLE=0, LOAD=1, DONE=2, ABORT=3) and defaults for BURST_LEN/TIMEOUT.
- Sub-module mop_rr_arb: combinational round-robin picker. Inputs are req vector and rr_ptr; output is one-hot winner plus index.

## Test plan
- Single burst: req_i=4'b0001, tgt=3, 8 back-to-back valid values 0x10..0x17.
  - Required: gnt_o=0001; 8 one-cycle load_ctrl_o=16'h0008 pulses with values 0x10..0x17.
  - Required: done_o[0] 1 cycle after the last strobe; total 10 cycles.
- Round-robin: req_i=4'b1111 held, rr_ptr=0.
  - Required: grants in order 0,1,2,3,0; each done_o is followed by the next grant after a 1-cycle gap.
- Lock/range: lock_i[5]=1, requester 2 targets 5. With NB_TGT=16, requester 1 targets 16 (TW=5 build).
  - Required: abort_o pulse 2 cycles after req_i, zero load_ctrl_o activity.
- Timeout: TIMEOUT=4; 3 values sent, then data_valid_i low.
  - Required: abort_o after 4 idle cycles; count discarded; next request starts fresh.
- Drop/reset mid-burst: req_i[winner] falls after value 2 (abort_o, no further strobe). Separately, rst_ni pulsed at value 5.
  - Required on reset: all outputs 0 asynchronously; no done/abort pulse.

Source files
------------

// File: rtl/mop_load_sched_pkg.sv
// Shared types for the debug MOP instruction-load scheduler.
// FSM state encoding plus default burst length and timeout.
package mop_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_e;

  localparam int BURST_LEN_DEF = 8;
  localparam int TIMEOUT_DEF   = 255;

endpackage

// File: rtl/mop_rr_arb.sv
// Combinational round-robin picker.
// Searches upward from ptr_i with wrap; returns one-hot and index.
module mop_rr_arb #(
  parameter int NB_REQ = 4,
  parameter int IW     = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              vld_o
);

  logic [IW-1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      c = IW'((int'(ptr_i) + i) % NB_REQ);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/mop_load_sched.sv
// Round-robin arbiter and burst sequencer for the MOP load path.
// Streams one requester's burst onto the shared value/strobe pair.
module mop_load_sched
  import mop_sched_pkg::*;
#(
  parameter int NB_REQ    = 4,
  parameter int NB_TGT    = 16,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TW        = $clog2(NB_TGT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NB_REQ-1:0]    req_i,
  input  logic [NB_REQ*TW-1:0] tgt_i,
  input  logic [NB_REQ*8-1:0]  data_i,
  input  logic [NB_REQ-1:0]    data_valid_i,
  input  logic [NB_TGT-1:0]    lock_i,
  output logic [NB_REQ-1:0]    data_ready_o,
  output logic [NB_REQ-1:0]    gnt_o,
  output logic [NB_REQ-1:0]    done_o,
  output logic [NB_REQ-1:0]    abort_o,
  output logic [NB_TGT-1:0]    load_ctrl_o,
  output logic [7:0]           instrut_value_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NB_REQ);

  state_e            state_q;
  logic [NB_REQ-1:0] gnt_q, done_q, abort_q;
  logic [IW-1:0]     win_q, rr_q;
  logic [TW-1:0]     tgt_q;
  logic [3:0]        cnt_q;
  logic [7:0]        tmr_q, val_q;
  logic [NB_TGT-1:0] lctl_q;
  logic              busy_q;

  logic [NB_REQ-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx, rr_nxt;
  logic              arb_vld;
  logic [TW-1:0]     new_tgt;
  logic              new_bad, cur_lock, xfer;
  logic [NB_TGT-1:0] tgt_oh;

  mop_rr_arb #(
    .NB_REQ (NB_REQ),
    .IW     (IW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Out-of-range indices read as unlocked; range is checked separately.
  function automatic logic bit_at(
    input logic [NB_TGT-1:0] v,
    input logic [TW-1:0]     t
  );
    logic b;
    b = 1'b0;
    for (int k = 0; k < NB_TGT; k++)
      if (int'(t) == k) b = v[k];
    return b;
  endfunction

  assign new_tgt  = tgt_i[arb_idx*TW +: TW];
  assign new_bad  = (int'(new_tgt) >= NB_TGT) ||
                    bit_at(lock_i, new_tgt);
  assign cur_lock = bit_at(lock_i, tgt_q);
  assign xfer     = data_valid_i[win_q] & data_ready_o[win_q];
  assign rr_nxt   = (int'(win_q) == NB_REQ-1) ? '0 : win_q + 1'b1;

  always_comb begin
    tgt_oh = '0;
    for (int k = 0; k < NB_TGT; k++)
      if (int'(tgt_q) == k) tgt_oh[k] = 1'b1;
  end

  assign data_ready_o = (state_q == LOAD) ? gnt_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= '0;
      win_q   <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      val_q   <= '0;
      lctl_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q  <= '0;
      abort_q <= '0;
      lctl_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_vld) begin
            gnt_q   <= arb_gnt;
            win_q   <= arb_idx;
            tgt_q   <= new_tgt;
            cnt_q   <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= new_bad ? ABORT : LOAD;
          end
        end
        LOAD: begin
          // Drop or lock beats a same-cycle handshake.
          if (!req_i[win_q] || cur_lock) begin
            state_q <= ABORT;
          end else if (xfer) begin
            val_q  <= data_i[win_q*8 +: 8];
            lctl_q <= tgt_oh;
            cnt_q  <= cnt_q + 4'd1;
            tmr_q  <= '0;
            if (cnt_q == 4'(BURST_LEN-1)) state_q <= DONE;
          end else begin
            tmr_q <= tmr_q + 8'd1;
            if (tmr_q == 8'(TIMEOUT-1)) state_q <= ABORT;
          end
        end
        DONE: begin
          done_q  <= gnt_q;
          gnt_q   <= '0;
          rr_q    <= rr_nxt;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ABORT: begin
          abort_q <= gnt_q;
          gnt_q   <= '0;
          rr_q    <= rr_nxt;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o           = gnt_q;
  assign done_o          = done_q;
  assign abort_o         = abort_q;
  assign load_ctrl_o     = lctl_q;
  assign instrut_value_o = val_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_mop_load_sched.sv
// Directed self-checking bench for mop_load_sched.
// Built with TIMEOUT=4 and TW=5 so timeout and range cases are reachable.
module tb_mop_load_sched;

  localparam int NB_REQ = 4;
  localparam int NB_TGT = 16;
  localparam int TW     = 5;

  logic                 clk, rst_n;
  logic [NB_REQ-1:0]    req, dv;
  logic [NB_REQ*TW-1:0] tgt;
  logic [NB_REQ*8-1:0]  data;
  logic [NB_TGT-1:0]    lock;
  logic [NB_REQ-1:0]    ready, gnt, done, abrt;
  logic [NB_TGT-1:0]    lctl;
  logic [7:0]           val;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  mop_load_sched #(
    .NB_REQ    (NB_REQ),
    .NB_TGT    (NB_TGT),
    .BURST_LEN (8),
    .TIMEOUT   (4),
    .TW        (TW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .tgt_i           (tgt),
    .data_i          (data),
    .data_valid_i    (dv),
    .lock_i          (lock),
    .data_ready_o    (ready),
    .gnt_o           (gnt),
    .done_o          (done),
    .abort_o         (abrt),
    .load_ctrl_o     (lctl),
    .instrut_value_o (val),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_tgt(input int r, input int t);
    tgt[r*TW +: TW] = TW'(t);
  endtask

  task automatic set_data(input int r, input logic [7:0] v);
    data[r*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; dv = '0; tgt = '0; data = '0; lock = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin
      failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt);
    end
    checks++;
    if (ready !== 4'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", ready);
    end
    checks++;
    if (done !== 4'b0 || abrt !== 4'b0) begin
      failures++;
      $display("FAIL reset_pulse done=%b abort=%b exp=0", done, abrt);
    end
    checks++;
    if (lctl !== 16'h0 || val !== 8'h0) begin
      failures++;
      $display("FAIL reset_load got=%h/%h exp=0/0", lctl, val);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_tgt(0, 3); set_data(0, 8'h10);
    req = 4'b0001; dv = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_gnt gnt=%b busy=%b rdy=%b exp=0001/1/0001",
               gnt, busy, ready);
    end
    checks++;
    if (lctl !== 16'h0) begin
      failures++; $display("FAIL single_nostrobe got=%h exp=0", lctl);
    end
    for (int k = 0; k < 8; k++) begin
      set_data(0, 8'(8'h10 + k));
      @(negedge clk);
      checks++;
      if (lctl !== 16'h0008 || val !== 8'(8'h10 + k) || done !== 4'b0) begin
        failures++;
        $display("FAIL single_strobe%0d got=%h/%h/%b exp=0008/%h/0000",
                 k, lctl, val, done, 8'(8'h10 + k));
      end
    end
    dv = '0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || lctl !== 16'h0 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL single_done done=%b lctl=%h gnt=%b exp=0001/0/0000",
               done, lctl, gnt);
    end
    checks++;
    if (val !== 8'h17 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_hold val=%h busy=%b exp=17/0", val, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0) begin
      failures++; $display("FAIL single_donepulse got=%b exp=0000", done);
    end
  endtask

  task automatic test_round_robin();
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    int n;
    do_reset();
    for (int r = 0; r < NB_REQ; r++) begin
      set_tgt(r, r + 8); set_data(r, 8'(r + 1));
    end
    dv = 4'hF; req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      e = 4'b0001 << ord[i];
      n = 0;
      while (gnt === 4'b0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (gnt !== e || n != 1) begin
        failures++;
        $display("FAIL rr_gnt%0d got=%b exp=%b wait=%0d exp_wait=1",
                 i, gnt, e, n);
      end
      n = 0;
      while (done === 4'b0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (done !== e || gnt !== 4'b0) begin
        failures++;
        $display("FAIL rr_done%0d got=%b gnt=%b exp=%b/0000",
                 i, done, gnt, e);
      end
      if (i == 4) req = '0;
    end
    dv = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin
      failures++; $display("FAIL rr_idle got=%b exp=0000", gnt);
    end
  endtask

  task automatic test_lock_range();
    lock = 16'h0020; set_tgt(2, 5); dv = '0;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || abrt !== 4'b0 || lctl !== 16'h0) begin
      failures++;
      $display("FAIL lock_gnt gnt=%b abort=%b lctl=%h exp=0100/0000/0",
               gnt, abrt, lctl);
    end
    @(negedge clk);
    checks++;
    if (abrt !== 4'b0100 || lctl !== 16'h0 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL lock_abort abort=%b lctl=%h gnt=%b exp=0100/0/0000",
               abrt, lctl, gnt);
    end
    req = '0; lock = '0;
    @(negedge clk);
    set_tgt(1, 16);
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || abrt !== 4'b0 || lctl !== 16'h0) begin
      failures++;
      $display("FAIL range_gnt gnt=%b abort=%b lctl=%h exp=0010/0000/0",
               gnt, abrt, lctl);
    end
    @(negedge clk);
    checks++;
    if (abrt !== 4'b0010 || lctl !== 16'h0) begin
      failures++;
      $display("FAIL range_abort abort=%b lctl=%h exp=0010/0",
               abrt, lctl);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    set_tgt(3, 7); req = 4'b1000; dv = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++; $display("FAIL to_gnt got=%b exp=1000", gnt);
    end
    for (int k = 0; k < 3; k++) begin
      set_data(3, 8'(8'h40 + k));
      @(negedge clk);
      checks++;
      if (lctl !== 16'h0080 || val !== 8'(8'h40 + k)) begin
        failures++;
        $display("FAIL to_strobe%0d got=%h/%h exp=0080/%h",
                 k, lctl, val, 8'(8'h40 + k));
      end
    end
    dv = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (abrt !== 4'b0 || lctl !== 16'h0) begin
        failures++;
        $display("FAIL to_wait%0d abort=%b lctl=%h exp=0000/0",
                 k, abrt, lctl);
      end
    end
    @(negedge clk);
    checks++;
    if (abrt !== 4'b1000) begin
      failures++; $display("FAIL to_abort got=%b exp=1000", abrt);
    end
    dv = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++; $display("FAIL to_regnt got=%b exp=1000", gnt);
    end
    for (int k = 0; k < 8; k++) begin
      set_data(3, 8'(8'h50 + k));
      @(negedge clk);
      checks++;
      if (lctl !== 16'h0080 || val !== 8'(8'h50 + k) || done !== 4'b0) begin
        failures++;
        $display("FAIL to_fresh%0d got=%h/%h/%b exp=0080/%h/0000",
                 k, lctl, val, done, 8'(8'h50 + k));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b1000) begin
      failures++; $display("FAIL to_done got=%b exp=1000", done);
    end
    req = '0; dv = '0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    set_tgt(1, 2); req = 4'b0010; dv = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_data(1, 8'(8'h30 + k));
      @(negedge clk);
      checks++;
      if (lctl !== 16'h0004 || val !== 8'(8'h30 + k)) begin
        failures++;
        $display("FAIL drop_strobe%0d got=%h/%h exp=0004/%h",
                 k, lctl, val, 8'(8'h30 + k));
      end
    end
    set_data(1, 8'h33); req = '0;
    @(negedge clk);
    checks++;
    if (lctl !== 16'h0 || val !== 8'h32 || abrt !== 4'b0) begin
      failures++;
      $display("FAIL drop_nostrobe got=%h/%h/%b exp=0/32/0000",
               lctl, val, abrt);
    end
    @(negedge clk);
    checks++;
    if (abrt !== 4'b0010 || lctl !== 16'h0) begin
      failures++;
      $display("FAIL drop_abort got=%b/%h exp=0010/0", abrt, lctl);
    end
    dv = '0;
    @(negedge clk);
  endtask

  task automatic test_lock_mid();
    set_tgt(0, 4); req = 4'b0001; dv = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      set_data(0, 8'(8'h60 + k));
      @(negedge clk);
    end
    checks++;
    if (lctl !== 16'h0010 || val !== 8'h61) begin
      failures++;
      $display("FAIL lmid_strobe got=%h/%h exp=0010/61", lctl, val);
    end
    lock = 16'h0010; set_data(0, 8'h62);
    @(negedge clk);
    checks++;
    if (lctl !== 16'h0 || val !== 8'h61) begin
      failures++;
      $display("FAIL lmid_nostrobe got=%h/%h exp=0/61", lctl, val);
    end
    @(negedge clk);
    checks++;
    if (abrt !== 4'b0001) begin
      failures++; $display("FAIL lmid_abort got=%b exp=0001", abrt);
    end
    lock = '0; req = '0; dv = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_tgt(2, 9); req = 4'b0100; dv = 4'b0100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      set_data(2, 8'(8'h70 + k));
      @(negedge clk);
      checks++;
      if (lctl !== 16'h0200 || val !== 8'(8'h70 + k)) begin
        failures++;
        $display("FAIL rmid_strobe%0d got=%h/%h exp=0200/%h",
                 k, lctl, val, 8'(8'h70 + k));
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || ready !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ctrl gnt=%b rdy=%b busy=%b exp=0/0/0",
               gnt, ready, busy);
    end
    checks++;
    if (lctl !== 16'h0 || val !== 8'h0) begin
      failures++;
      $display("FAIL rmid_load got=%h/%h exp=0/0", lctl, val);
    end
    req = '0; dv = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 4'b0 || abrt !== 4'b0 || lctl !== 16'h0 ||
          gnt !== 4'b0) begin
        failures++;
        $display("FAIL rmid_quiet%0d d=%b a=%b l=%h g=%b exp=all0",
                 k, done, abrt, lctl, gnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_range();
    test_timeout();
    test_drop();
    test_lock_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
